// File: rtl/blob_seq_pkg.sv
// Shared types and defaults for the blob frame sequencer.
package blob_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_END
  } state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int N_FRAMES_DEF = 4;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int CNT_W = 4;
  localparam int SUM_W = 16;

endpackage

// File: rtl/blob_frame_sequencer_sync_rise_detect.sv
// One-flop rising-edge detector; the history flop resets low so a level
// already high when reset releases is reported as a rise.
module sync_rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic d_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) d_q <= 1'b0;
    else          d_q <= i_d;
  end

  assign o_rise = i_d & ~d_q;

endmodule

// File: rtl/blob_frame_sequencer.sv
// Frame-level sequencer: arms on grayscale start, walks the active raster per
// frame, raises sticky blob end after N_FRAMES complete frames.
// Optional per-frame checksum when BLOB_SEQ_CHECKSUM_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for grayscale start
// S_ARM   | start seen, waiting for a frame boundary
// S_RUN   | accepting active pixels
// S_DRAIN | frame complete, waiting for the next boundary
// S_END   | blob finished, idle until reset
module blob_frame_sequencer
  import blob_seq_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int N_FRAMES = N_FRAMES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_grayscale_start,
  input  logic             i_vsync,
  input  logic             i_pix_valid,
  input  logic [7:0]       i_pix_data,
  output logic             o_frame_active,
  output logic [X_W-1:0]   o_x,
  output logic [Y_W-1:0]   o_y,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic             o_err_short,
  output logic             o_blob_end,
  output logic [SUM_W-1:0] o_frame_sum
);

  localparam logic [X_W-1:0]   X_LAST  = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_FRAMES);

  state_t             state_q, state_d;
  logic [X_W-1:0]     x_d;
  logic [Y_W-1:0]     y_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               done_d;
  logic               err_d;
  logic               frame_start;
  logic               pix_accept;
  logic               vsync_rise;

  sync_rise_detect u_vsync_rise (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_vsync),
    .o_rise  (vsync_rise)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = o_x;
    y_d         = o_y;
    cnt_d       = o_frame_cnt;
    done_d      = 1'b0;
    err_d       = o_err_short;
    frame_start = 1'b0;
    pix_accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_grayscale_start) state_d = S_ARM;
      end
      S_ARM: begin
        if (vsync_rise) begin
          state_d     = S_RUN;
          frame_start = 1'b1;
        end
      end
      S_RUN: begin
        // a boundary wins over a coincident pixel, which is dropped
        if (vsync_rise) begin
          done_d      = 1'b1;
          err_d       = 1'b1;
          frame_start = 1'b1;
          state_d     = i_grayscale_start ? S_RUN : S_IDLE;
        end else if (i_pix_valid) begin
          pix_accept = 1'b1;
          if (o_x == X_LAST) begin
            x_d = '0;
            if (o_y == Y_LAST) begin
              y_d     = '0;
              done_d  = 1'b1;
              state_d = S_DRAIN;
              if (o_frame_cnt != CNT_MAX) cnt_d = o_frame_cnt + 1'b1;
            end else begin
              y_d = o_y + 1'b1;
            end
          end else begin
            x_d = o_x + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (vsync_rise) begin
          if (o_frame_cnt == CNT_MAX) begin
            state_d = S_END;
          end else if (i_grayscale_start) begin
            state_d     = S_RUN;
            frame_start = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_END: begin
        state_d = S_END;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (frame_start) begin
      x_d = '0;
      y_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= S_IDLE;
      o_frame_active <= 1'b0;
      o_x            <= '0;
      o_y            <= '0;
      o_frame_done   <= 1'b0;
      o_frame_cnt    <= '0;
      o_err_short    <= 1'b0;
      o_blob_end     <= 1'b0;
    end else begin
      state_q        <= state_d;
      o_frame_active <= (state_d == S_RUN);
      o_x            <= x_d;
      o_y            <= y_d;
      o_frame_done   <= done_d;
      o_frame_cnt    <= cnt_d;
      o_err_short    <= err_d;
      o_blob_end     <= (state_d == S_END);
    end
  end

`ifdef BLOB_SEQ_CHECKSUM_EN
  logic [SUM_W-1:0] acc_q;
  logic [SUM_W-1:0] acc_nxt;
  logic [SUM_W-1:0] sum_q;

  assign acc_nxt = acc_q + SUM_W'(i_pix_data);

  // the closing pixel of a complete frame is folded in as the sum latches
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      if (frame_start)     acc_q <= '0;
      else if (pix_accept) acc_q <= acc_nxt;
      if (done_d)          sum_q <= pix_accept ? acc_nxt : acc_q;
    end
  end

  assign o_frame_sum = sum_q;
`else
  logic unused_cksum;
  assign unused_cksum = ^{i_pix_data, pix_accept};
  assign o_frame_sum  = '0;
`endif

endmodule
